shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Command-driven controller for the 8-bit ShiftRegister datapath. Accepts one shift command (op, amount, data, destination address) over a valid/ready handshake, then loads the register and steps it through the requested number of shift cycles. It raises the register's write-enable so `wr_en_ff`/`addr_ff` align with the final Q, and returns the result over a valid/ready response port. It sits between the instruction decode logic and the ShiftRegister instance.

## Interface
Parameters: none. All widths come from the `definitions` package.
- `DATAWIDTH`, 8: datapath width.
- `ADDRWIDTH`, package value: register-file address width.
- `SHAMTWIDTH`, `$clog2(DATAWIDTH)` = 3: shift-amount width.

Ports:
- `Clock`  in  1  sole clock, rising edge.
- `Clear`  in  1  reset, synchronous, active-low. The same net drives the ShiftRegister's `Clear`.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted on `cmd_valid && cmd_ready`.
- `cmd_op`  in  3  `shift_op_t`.
- `cmd_amt`  in  `SHAMTWIDTH`  shift count, 0..7.
- `cmd_data`  in  `DATAWIDTH`  initial value.
- `cmd_fill`  in  1  serial fill bit for SHR/SHL.
- `cmd_addr`  in  `ADDRWIDTH`  destination address.
- `sr_S`  out  3  ShiftRegister mode select.
- `sr_D`  out  `DATAWIDTH`  ShiftRegister parallel load data.
- `sr_MSBIn`, `sr_LSBIn`  out  1 each  serial inputs.
- `sr_wr_en`  out  1  write-enable pulse to the ShiftRegister.
- `sr_addr`  out  `ADDRWIDTH`  address to the ShiftRegister.
- `sr_Q`  in  `DATAWIDTH`  ShiftRegister output.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  result consumer ready.
- `rsp_data`  out  `DATAWIDTH`  result value.
- `rsp_addr`  out  `ADDRWIDTH`  result address.
- `busy`  out  1  high in any state other than IDLE.

## Operation
`shift_op_t` encoding, identical to ShiftRegister `S`:
- 0 HOLD
- 1 LOAD
- 2 SHR, `MSBIn` fill
- 3 SHL, `LSBIn` fill
- 4 ROR
- 5 ROL
- 6 ASR
- 7 SHL0

States:
- **IDLE**
  - `cmd_ready`=1.
  - On handshake, latch op/amt/data/fill/addr → LOAD.
- **LOAD**
  - `sr_S`=1, `sr_D`=latched data.
  - Effective amount is 0 if op ∈ {HOLD, LOAD} or amt==0; in that case → DONE.
  - Otherwise load the down-counter with amt → SHIFT.
- **SHIFT**
  - `sr_S`=op; counter decrements each cycle.
  - At counter==1 → DONE.
- **DONE**
  - `sr_S`=0 (HOLD), `rsp_valid`=1, `rsp_data`=`sr_Q`, `rsp_addr`=latched addr.
  - On `rsp_ready` → IDLE.

Serial inputs: `sr_MSBIn`=fill only when op==SHR; `sr_LSBIn`=fill only when op==SHL; both 0 otherwise.

Write-enable: `sr_wr_en`=1 and `sr_addr`=addr for exactly one cycle, the last Q-updating cycle (LOAD if the effective amount is 0, else the final SHIFT cycle). `sr_addr` is 0 when `sr_wr_en` is 0.

`sr_S` is 0 in IDLE and DONE.

Reset values (Clear low at an edge), all outputs 0 except `cmd_ready`=1:
- state=IDLE
- `sr_S`=0, `sr_wr_en`=0
- `rsp_valid`=0, `busy`=0
- counter=0

Reset mid-operation aborts the command. No response and no write pulse are produced; the ShiftRegister clears too.

## Timing
- Accept edge E0. LOAD in cycle 1. SHIFT in cycles 2..amt+1. `rsp_valid` first high in cycle amt+2 (2 for amount 0).
- `wr_en_ff`/`addr_ff` are high in the first DONE cycle, coincident with the final `sr_Q`.
- `rsp_*` is held stable while `rsp_valid && !rsp_ready`. `sr_Q` is held by HOLD. No second write pulse.
- `cmd_ready` is combinational from state (and buffer), never from `cmd_valid`.

## Configuration
Macro: `SHIFT_SEQ_CMD_BUF_EN`.
- **Without it:** `cmd_ready`=1 only in IDLE.
- **With it:** a one-entry command buffer is added and `cmd_ready`=!buf_valid in every state.
  - A command accepted while busy is stored.
  - On the DONE handshake with buf_valid=1, go directly to LOAD with the buffered command (no IDLE cycle).
  - In IDLE, an incoming command bypasses the empty buffer.
  - A simultaneous DONE-exit and new-command arrival with a full buffer is impossible, because `cmd_ready`=0 when the buffer is full.
  - Clear empties the buffer.

## Structure
- `definitions` gains:
  - `shift_op_t` (enum, encodings above)
  - `SHAMTWIDTH`
  - `seq_state_t` {IDLE, LOAD, SHIFT, DONE}
- One sub-module, `shift_cmd_buf`: a one-entry valid/data holding register, instantiated only under `SHIFT_SEQ_CMD_BUF_EN`.

## Test plan
- **Reset:** Clear low 2 cycles → `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `sr_S`=0, `sr_wr_en`=0.
- **SHL0:** op=7, data=8'h0F, amt=3, addr=5 → `rsp_valid` in cycle 5 after accept, `rsp_data`=8'h78. `wr_en_ff`=1 and `addr_ff`=5 in that same cycle.
- **ASR and rotates:**
  - ASR 8'h90 amt 2 → 8'hE4.
  - ROL 8'h81 amt 1 → 8'h03.
  - ROR 8'h81 amt 4 → 8'h18.
- **Fill and amount 0:**
  - SHR fill=1, 8'h00, amt 3 → 8'hE0.
  - LOAD 8'h5A, amt 6 → 8'h5A, response in cycle 2.
- **Backpressure and abort:**
  - `rsp_ready` low 3 cycles → `rsp_data` stable, `sr_S`=0, a single write pulse.
  - Clear low mid-SHIFT → IDLE next cycle, no `rsp_valid`.
- **Buffer (`SHIFT_SEQ_CMD_BUF_EN` defined):** second command offered during the first's SHIFT → accepted. Its LOAD occurs in the cycle after the first response handshake, and `cmd_ready`=0 while the buffer is full.

Source files
------------

// File: rtl/definitions.sv
// Shared definitions for the shift_sequencer controller and its ShiftRegister.
//
// Contents:
//   DATAWIDTH   - datapath width (8)
//   ADDRWIDTH   - register-file address width
//   SHAMTWIDTH  - shift-amount width, $clog2(DATAWIDTH)
//   shift_op_t  - ShiftRegister mode encoding (same values as the S select)
//   seq_state_t - sequencer FSM states
//   cmd_t       - one latched shift command
//   amount_is_zero() - true when a command needs no shift cycles
package definitions;

  localparam int DATAWIDTH  = 8;
  localparam int ADDRWIDTH  = 5;
  localparam int SHAMTWIDTH = $clog2(DATAWIDTH);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ASR  = 3'd6,
    OP_SHL0 = 3'd7
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } seq_state_t;

  typedef struct packed {
    shift_op_t              op;
    logic [SHAMTWIDTH-1:0]  amt;
    logic [DATAWIDTH-1:0]   data;
    logic                   fill;
    logic [ADDRWIDTH-1:0]   addr;
  } cmd_t;

  localparam int CMDWIDTH = $bits(cmd_t);

  localparam logic [SHAMTWIDTH-1:0] CNT_ONE = SHAMTWIDTH'(1);

  // HOLD and LOAD never shift, so their requested amount is ignored.
  function automatic logic amount_is_zero(input cmd_t cmd);
    return (cmd.op == OP_HOLD) || (cmd.op == OP_LOAD) || (cmd.amt == '0);
  endfunction

endpackage

// File: rtl/shift_cmd_buf.sv
// One-entry command holding register for shift_sequencer.
// Only present when SHIFT_SEQ_CMD_BUF_EN is defined.
//
// Ports:
//   clk   - clock, rising edge
//   clear - synchronous active-low reset; empties the entry
//   push  - store din (only issued while the entry is empty)
//   pop   - release the entry (only issued while it is full)
//   din   - command to store
//   valid - entry holds a command
//   dout  - stored command
`ifdef SHIFT_SEQ_CMD_BUF_EN
module shift_cmd_buf
  import definitions::*;
(
  input  logic                clk,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  logic [CMDWIDTH-1:0] din,
  output logic                valid,
  output logic [CMDWIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (!clear) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while valid is set.
  always_ff @(posedge clk) begin
    if (push) begin
      dout <= din;
    end
  end

endmodule
`endif

// File: rtl/shift_sequencer.sv
// Command-driven controller for the 8-bit ShiftRegister datapath.
// Accepts one shift command over cmd_valid/cmd_ready, loads the register,
// steps it through the requested shifts, pulses the register write-enable on
// the last Q-updating cycle and returns the result over rsp_valid/rsp_ready.
//
// Optional feature macro: SHIFT_SEQ_CMD_BUF_EN adds a one-entry command
// buffer so a new command can be accepted while a previous one is running.
//
// Ports:
//   Clock, Clear           - clock; synchronous active-low reset
//   cmd_valid/cmd_ready    - command handshake
//   cmd_op/amt/data/fill/addr - command fields
//   sr_S, sr_D             - ShiftRegister mode select and parallel data
//   sr_MSBIn, sr_LSBIn     - serial fill inputs
//   sr_wr_en, sr_addr      - write-enable pulse and address
//   sr_Q                   - ShiftRegister output
//   rsp_valid/rsp_ready    - response handshake
//   rsp_data, rsp_addr     - result value and destination address
//   busy                   - any state other than IDLE
import definitions::*;

module shift_sequencer (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [SHAMTWIDTH-1:0] cmd_amt,
  input  logic [DATAWIDTH-1:0]  cmd_data,
  input  logic                  cmd_fill,
  input  logic [ADDRWIDTH-1:0]  cmd_addr,
  output logic [2:0]            sr_S,
  output logic [DATAWIDTH-1:0]  sr_D,
  output logic                  sr_MSBIn,
  output logic                  sr_LSBIn,
  output logic                  sr_wr_en,
  output logic [ADDRWIDTH-1:0]  sr_addr,
  input  logic [DATAWIDTH-1:0]  sr_Q,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATAWIDTH-1:0]  rsp_data,
  output logic [ADDRWIDTH-1:0]  rsp_addr,
  output logic                  busy
);

  seq_state_t            state, state_nxt;
  logic [SHAMTWIDTH-1:0] cnt;
  cmd_t                  cmd_q;
  cmd_t                  cmd_in;
  cmd_t                  start_cmd;
  logic                  accept;
  logic                  start;
  logic                  eff_zero;

  always_comb begin
    cmd_in      = '0;
    cmd_in.op   = shift_op_t'(cmd_op);
    cmd_in.amt  = cmd_amt;
    cmd_in.data = cmd_data;
    cmd_in.fill = cmd_fill;
    cmd_in.addr = cmd_addr;
  end

`ifdef SHIFT_SEQ_CMD_BUF_EN
  logic                buf_valid;
  logic                buf_push;
  logic                buf_pop;
  logic [CMDWIDTH-1:0] buf_dout;

  assign cmd_ready = !buf_valid;
  assign accept    = cmd_valid && cmd_ready;
  // In IDLE the buffer is necessarily empty when ready, so the command
  // bypasses it; anywhere else it is parked for later.
  assign buf_push  = accept && (state != IDLE);
  // A parked command starts either from IDLE (it arrived on the DONE exit
  // cycle) or straight out of DONE without an IDLE bubble.
  assign buf_pop   = buf_valid && ((state == IDLE) || ((state == DONE) && rsp_ready));
  assign start     = buf_pop || (accept && (state == IDLE));
  assign start_cmd = buf_pop ? cmd_t'(buf_dout) : cmd_in;

  shift_cmd_buf u_cmd_buf (
    .clk   (Clock),
    .clear (Clear),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (cmd_in),
    .valid (buf_valid),
    .dout  (buf_dout)
  );
`else
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign start     = accept;
  assign start_cmd = cmd_in;
`endif

  assign eff_zero = amount_is_zero(cmd_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = eff_zero ? DONE : SHIFT;
      SHIFT:   if (cnt == CNT_ONE) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        cnt <= cmd_q.amt;
      end else if (state == SHIFT) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // Command payload is only consumed in LOAD/SHIFT/DONE, so it is not reset.
  always_ff @(posedge Clock) begin
    if (start) begin
      cmd_q <= start_cmd;
    end
  end

  always_comb begin
    sr_S      = 3'(OP_HOLD);
    sr_D      = '0;
    sr_MSBIn  = 1'b0;
    sr_LSBIn  = 1'b0;
    sr_wr_en  = 1'b0;
    sr_addr   = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_addr  = '0;
    busy      = (state != IDLE);
    case (state)
      LOAD: begin
        sr_S     = 3'(OP_LOAD);
        sr_D     = cmd_q.data;
        sr_wr_en = eff_zero;
      end
      SHIFT: begin
        sr_S     = cmd_q.op;
        sr_MSBIn = (cmd_q.op == OP_SHR) && cmd_q.fill;
        sr_LSBIn = (cmd_q.op == OP_SHL) && cmd_q.fill;
        // Final shift: the register captures wr_en/addr with the last Q.
        sr_wr_en = (cnt == CNT_ONE);
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = sr_Q;
        rsp_addr  = cmd_q.addr;
      end
      default: ;
    endcase
    if (sr_wr_en) begin
      sr_addr = cmd_q.addr;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer. A small ShiftRegister stand-in
// closes the sr_* loop; expected results come from an arithmetic model.
module tb_shift_sequencer;
  import definitions::*;

  logic                  Clock = 1'b0;
  logic                  Clear = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [2:0]            cmd_op = '0;
  logic [SHAMTWIDTH-1:0] cmd_amt = '0;
  logic [DATAWIDTH-1:0]  cmd_data = '0;
  logic                  cmd_fill = 1'b0;
  logic [ADDRWIDTH-1:0]  cmd_addr = '0;
  logic [2:0]            sr_S;
  logic [DATAWIDTH-1:0]  sr_D;
  logic                  sr_MSBIn, sr_LSBIn, sr_wr_en;
  logic [ADDRWIDTH-1:0]  sr_addr;
  logic [DATAWIDTH-1:0]  sr_Q;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [DATAWIDTH-1:0]  rsp_data;
  logic [ADDRWIDTH-1:0]  rsp_addr;
  logic                  busy;

  logic                  wr_en_ff;
  logic [ADDRWIDTH-1:0]  addr_ff;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;

  always #5 Clock = ~Clock;

  shift_sequencer dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .cmd_fill  (cmd_fill),
    .cmd_addr  (cmd_addr),
    .sr_S      (sr_S),
    .sr_D      (sr_D),
    .sr_MSBIn  (sr_MSBIn),
    .sr_LSBIn  (sr_LSBIn),
    .sr_wr_en  (sr_wr_en),
    .sr_addr   (sr_addr),
    .sr_Q      (sr_Q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .busy      (busy)
  );

  // ShiftRegister stand-in, sharing Clear with the sequencer.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      sr_Q     <= '0;
      wr_en_ff <= 1'b0;
      addr_ff  <= '0;
    end else begin
      case (sr_S)
        3'd1:    sr_Q <= sr_D;
        3'd2:    sr_Q <= {sr_MSBIn, sr_Q[7:1]};
        3'd3:    sr_Q <= {sr_Q[6:0], sr_LSBIn};
        3'd4:    sr_Q <= {sr_Q[0], sr_Q[7:1]};
        3'd5:    sr_Q <= {sr_Q[6:0], sr_Q[7]};
        3'd6:    sr_Q <= {sr_Q[7], sr_Q[7:1]};
        3'd7:    sr_Q <= {sr_Q[6:0], 1'b0};
        default: sr_Q <= sr_Q;
      endcase
      wr_en_ff <= sr_wr_en;
      addr_ff  <= sr_addr;
    end
  end

  always @(posedge Clock) begin
    if (Clear && sr_wr_en) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result of a command, by repeated arithmetic on an integer.
  function automatic logic [7:0] ref_shift(input int op, input int amt, input logic [7:0] d, input int fill);
    int v;
    v = int'(d);
    if (op < 2) return d;
    for (int i = 0; i < amt; i++) begin
      case (op)
        2: v = (v >> 1) | (fill * 128);
        3: v = ((v * 2) & 255) | fill;
        4: v = (v >> 1) | ((v & 1) * 128);
        5: v = ((v * 2) & 255) | (v >> 7);
        6: v = (v >> 1) | (v & 128);
        default: v = (v * 2) & 255;
      endcase
    end
    return v[7:0];
  endfunction

  function automatic int ref_latency(input int op, input int amt);
    return (op < 2 || amt == 0) ? 2 : amt + 2;
  endfunction

  task automatic drive_cmd(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data,
                           input logic fill, input logic [ADDRWIDTH-1:0] addr);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    cmd_fill  = fill;
    cmd_addr  = addr;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data,
                         input logic fill, input logic [ADDRWIDTH-1:0] addr, input int stall);
    logic [7:0] exp_d;
    logic [7:0] held;
    int         cyc;
    exp_d = ref_shift(int'(op), int'(amt), data, int'(fill));
    @(negedge Clock);
    check("cmd_ready_idle", cmd_ready, 1);
    drive_cmd(op, amt, data, fill, addr);
    rsp_ready = (stall == 0);
    wr_cnt = 0;
    @(posedge Clock);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    cmd_addr  = ADDRWIDTH'($urandom);
    cyc = 0;
    do begin
      @(negedge Clock);
      cyc++;
      if (cyc == 1) begin
        check("busy_run", busy, 1);
`ifdef SHIFT_SEQ_CMD_BUF_EN
        check("cmd_ready_busy", cmd_ready, 1);
`else
        check("cmd_ready_busy", cmd_ready, 0);
`endif
      end
    end while (!rsp_valid && cyc < 20);
    check("rsp_latency", cyc, ref_latency(int'(op), int'(amt)));
    check("rsp_data", rsp_data, exp_d);
    check("rsp_addr", rsp_addr, addr);
    check("wr_en_ff", wr_en_ff, 1);
    check("addr_ff", addr_ff, addr);
    check("sr_S_done", sr_S, 0);
    held = rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge Clock);
      check("rsp_hold", {rsp_valid, rsp_data, sr_S, wr_en_ff}, {1'b1, held, 3'b000, 1'b0});
    end
    rsp_ready = 1'b1;
    @(negedge Clock);
    check("wr_pulses", wr_cnt, 1);
    check("idle_after", busy, 0);
  endtask

  initial begin
    int cyc;
    int seen;
    // Reset
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sr_S", sr_S, 0);
    check("rst_sr_wr_en", sr_wr_en, 0);
    Clear = 1'b1;

    // Directed cases
    run_cmd(3'd7, 3'd3, 8'h0F, 1'b0, 5'd5, 0);
    run_cmd(3'd6, 3'd2, 8'h90, 1'b0, 5'd1, 0);
    run_cmd(3'd5, 3'd1, 8'h81, 1'b0, 5'd2, 0);
    run_cmd(3'd4, 3'd4, 8'h81, 1'b0, 5'd3, 0);
    run_cmd(3'd2, 3'd3, 8'h00, 1'b1, 5'd4, 0);
    run_cmd(3'd3, 3'd2, 8'h00, 1'b1, 5'd6, 0);
    run_cmd(3'd1, 3'd6, 8'h5A, 1'b0, 5'd7, 0);
    run_cmd(3'd0, 3'd5, 8'hC3, 1'b0, 5'd8, 0);
    run_cmd(3'd7, 3'd0, 8'hA5, 1'b0, 5'd9, 0);
    run_cmd(3'd4, 3'd7, 8'h01, 1'b0, 5'd31, 3);

    // Abort mid-SHIFT
    @(negedge Clock);
    drive_cmd(3'd5, 3'd6, 8'h3C, 1'b0, 5'd10);
    wr_cnt = 0;
    @(posedge Clock);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge Clock);
    check("abort_in_shift", sr_S, 5);
    Clear = 1'b0;
    @(negedge Clock);
    Clear = 1'b1;
    check("abort_idle", {busy, rsp_valid, cmd_ready, sr_S}, {1'b0, 1'b0, 1'b1, 3'b000});
    check("abort_q_cleared", sr_Q, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);
    check("abort_no_wr", wr_cnt, 0);

`ifdef SHIFT_SEQ_CMD_BUF_EN
    // Second command parked during the first one's SHIFT
    @(negedge Clock);
    drive_cmd(3'd7, 3'd3, 8'h0F, 1'b0, 5'd5);
    rsp_ready = 1'b1;
    @(posedge Clock);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge Clock);
    check("buf_ready_empty", cmd_ready, 1);
    drive_cmd(3'd6, 3'd2, 8'h90, 1'b0, 5'd11);
    @(posedge Clock);
    #1;
    cmd_valid = 1'b0;
    @(negedge Clock);
    check("buf_ready_full", cmd_ready, 0);
    cyc = 3;
    while (!rsp_valid && cyc < 20) begin
      @(negedge Clock);
      cyc++;
    end
    check("buf_first_lat", cyc, 5);
    check("buf_first_data", rsp_data, 8'h78);
    @(negedge Clock);
    check("buf_direct_load", {busy, rsp_valid, sr_S}, {1'b1, 1'b0, 3'b001});
    check("buf_load_data", sr_D, 8'h90);
    check("buf_ready_after", cmd_ready, 1);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(negedge Clock);
      cyc++;
    end
    check("buf_second_lat", cyc, 4);
    check("buf_second_data", rsp_data, 8'hE4);
    check("buf_second_addr", rsp_addr, 11);
    @(negedge Clock);
`endif

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom),
              1'($urandom), ADDRWIDTH'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
